// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage definitions: redirect request kinds and the sequencer state encoding.
package mips_pkg;

    localparam logic [1:0] KIND_J    = 2'd0;
    localparam logic [1:0] KIND_BR   = 2'd1;
    localparam logic [1:0] KIND_JR   = 2'd2;
    localparam logic [1:0] KIND_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

endpackage

// File: rtl/jump_target_calc.sv
// Combinational redirect target generation for J, taken-branch and JR requests.
module jump_target_calc
    import mips_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int INDEX_W  = 26,
    parameter int OFFSET_W = 16
) (
    input  logic [WIDTH-1:0]    pc_plus4,
    input  logic [1:0]          kind,
    input  logic [INDEX_W-1:0]  instr_index,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic [WIDTH-1:0]    jr_target,
    output logic [WIDTH-1:0]    target,
    output logic                misaligned
);

    localparam int REGION_W = WIDTH - INDEX_W - 2;
    localparam int SEXT_W   = WIDTH - OFFSET_W - 2;

    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] br_disp;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] jr_tgt;

    // Jump keeps the region bits of the delay-slot address, as in the original MIPS J logic.
    assign j_tgt   = {pc_plus4[WIDTH-1 -: REGION_W], instr_index, 2'b00};
    assign br_disp = {{SEXT_W{br_offset[OFFSET_W-1]}}, br_offset, 2'b00};
    assign br_tgt  = pc_plus4 + br_disp;
    assign jr_tgt  = {jr_target[WIDTH-1:2], 2'b00};

    always_comb begin
        target = '0;
        case (kind)
            KIND_J:  target = j_tgt;
            KIND_BR: target = br_tgt;
            KIND_JR: target = jr_tgt;
            default: target = '0;
        endcase
    end

    assign misaligned = (kind == KIND_JR) && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with J/BRANCH/JR redirects and an optional branch-delay slot.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          INDEX_W    = 26,
    parameter int          OFFSET_W   = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int          DELAY_SLOT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                req_valid,
    input  logic [1:0]          req_kind,
    input  logic [INDEX_W-1:0]  instr_index,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic [WIDTH-1:0]    jr_target,
    output logic                req_ready,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_plus4,
    output logic                pending,
    output logic                addr_err
);

    state_t           state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] tgt_reg;
    logic             addr_err_reg;

    logic [WIDTH-1:0] target;
    logic             misaligned;
    logic             accept;

    jump_target_calc #(
        .WIDTH    (WIDTH),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W)
    ) u_calc (
        .pc_plus4    (pc_plus4),
        .kind        (req_kind),
        .instr_index (instr_index),
        .br_offset   (br_offset),
        .jr_target   (jr_target),
        .target      (target),
        .misaligned  (misaligned)
    );

    assign pc_plus4  = pc_reg + WIDTH'(4);
    assign req_ready = (state_reg == ST_IDLE) && !stall;
    // Reserved kind behaves like no request apart from the error pulse.
    assign accept    = req_ready && req_valid && (req_kind != KIND_RSVD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            tgt_reg      <= '0;
            addr_err_reg <= 1'b0;
        end else if (stall) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= req_ready && req_valid &&
                            ((req_kind == KIND_RSVD) || misaligned);
            case (state_reg)
                ST_IDLE: begin
                    if (accept && (DELAY_SLOT != 0)) begin
                        tgt_reg   <= target;
                        pc_reg    <= pc_plus4;
                        state_reg <= ST_SLOT;
                    end else if (accept) begin
                        pc_reg    <= target;
                    end else begin
                        pc_reg    <= pc_plus4;
                    end
                end
                ST_SLOT: begin
                    pc_reg    <= tgt_reg;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign pc       = pc_reg;
    assign pending  = (state_reg == ST_SLOT);
    assign addr_err = addr_err_reg;

endmodule
